clken_gen: RTL

Parametrised clock-enable generator fed by the PLL master clock. It derives `NUM_CH` independent fractional-rate enable pulses and divided square waves from the single master clock, using one phase accumulator per channel. Each channel's rate can be retuned at run time without glitches, and all outputs are held off until the PLL reports lock and a settle interval has elapsed. Emulation logic (CPU, video, sound, tape) clocks on the master clock and qualifies its logic with these enables.

---
 rtl/clken_gen_if.sv | 27 ++
 rtl/clken_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/clken_gen_if.sv
// Configuration and enable-output bundle for clken_gen.
// master = controller/CPU side, slave = the generator itself.
interface clken_gen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic              cfg_en;
  logic              ready;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] cfg_pending;

  modport master (
    output cfg_wr, cfg_ch, cfg_inc, cfg_en,
    input  ready, ce, clk_div, cfg_pending
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_inc, cfg_en,
    output ready, ce, clk_div, cfg_pending
  );
endinterface

// File: rtl/clken_gen.sv
// Fractional clock-enable generator: one phase accumulator per channel, gated by
// a PLL-lock settle FSM, with carry-aligned (glitch-free) increment retuning.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | PLL not locked; accumulators and outputs held at zero
// S_SETTLE | lock seen, settle timer counting down to terminal count
// S_RUN    | ready=1, accumulators advance every cycle
module clken_gen #(
  parameter int NUM_CH        = 4,
  parameter int ACC_W         = 24,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic  refclk,
  input  logic  rst_n,
  input  logic  pll_locked,
  clken_gen_if.slave bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] settle_cnt;
  logic             run_add;

  logic [ACC_W-1:0] acc    [NUM_CH];
  logic [ACC_W-1:0] inc    [NUM_CH];
  logic [ACC_W-1:0] inc_sh [NUM_CH];
  logic [ACC_W:0]   sum    [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ce_q;
  logic [NUM_CH-1:0] div_q;
  logic [NUM_CH-1:0] wr_hit;
  logic              ch_ok;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else if (!pll_locked) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state      <= S_SETTLE;
          settle_cnt <= CNT_LOAD;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_RUN;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Losing lock in RUN suppresses the add so ce/clk_div drop together with ready.
  assign run_add = (state == S_RUN) && pll_locked;
  assign ch_ok   = ({1'b0, bus.cfg_ch} < NUM_CH_L);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = bus.cfg_wr && ch_ok && (bus.cfg_ch == CH_W'(i));
      sum[i]    = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]    <= '0;
        inc[i]    <= '0;
        inc_sh[i] <= '0;
      end
      en      <= '0;
      pending <= '0;
      ce_q    <= '0;
      div_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!run_add) begin
          acc[i]   <= '0;
          ce_q[i]  <= 1'b0;
          div_q[i] <= 1'b0;
          if (wr_hit[i]) begin
            inc[i]     <= bus.cfg_inc;
            en[i]      <= bus.cfg_en;
            pending[i] <= 1'b0;
          end
        end else if (wr_hit[i] && (!bus.cfg_en || !en[i])) begin
          inc[i]     <= bus.cfg_inc;
          en[i]      <= bus.cfg_en;
          pending[i] <= 1'b0;
          acc[i]     <= '0;
          ce_q[i]    <= 1'b0;
          div_q[i]   <= 1'b0;
        end else if (en[i]) begin
          acc[i]  <= sum[i][ACC_W-1:0];
          ce_q[i] <= sum[i][ACC_W];
          if (sum[i][ACC_W]) div_q[i] <= ~div_q[i];
          // A write in the carry cycle wins: it re-arms the shadow for the next carry.
          if (wr_hit[i]) begin
            inc_sh[i]  <= bus.cfg_inc;
            pending[i] <= 1'b1;
          end else if (sum[i][ACC_W] && pending[i]) begin
            inc[i]     <= inc_sh[i];
            pending[i] <= 1'b0;
          end
        end else begin
          ce_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.ready       = (state == S_RUN);
  assign bus.ce          = ce_q;
  assign bus.clk_div     = div_q;
  assign bus.cfg_pending = pending;

endmodule
